// File: rtl/rv523_pkg.sv
// Shared types for the serial shifter: operation encoding and FSM state.
package rv523_pkg;

    // Operation encoding as presented on op_i.
    typedef enum logic [1:0] {
        OpSll = 2'b00,
        OpSrl = 2'b01,
        OpSra = 2'b10,
        OpRol = 2'b11
    } shift_op_e;

    // Controller states; the fourth encoding is unused and recovers to idle.
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } shifter_state_e;

    // Smallest legal data width.
    localparam int unsigned MinWidth = 2;

endpackage : rv523_pkg

// File: rtl/rv523_shift_step.sv
// Single-bit shift/rotate step. Purely combinational; one instance serves every op.
module rv523_shift_step
    import rv523_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc_i,
    input  shift_op_e        op_i,
    output logic [WIDTH-1:0] acc_o
);

    // Select the one-position move for the current operation.
    always_comb begin
        acc_o = acc_i;
        unique case (op_i)
            OpSll:   acc_o = {acc_i[WIDTH-2:0], 1'b0};
            OpSrl:   acc_o = {1'b0, acc_i[WIDTH-1:1]};
            OpSra:   acc_o = {acc_i[WIDTH-1], acc_i[WIDTH-1:1]};
            OpRol:   acc_o = {acc_i[WIDTH-2:0], acc_i[WIDTH-1]};
            default: acc_o = acc_i;
        endcase
    end

endmodule : rv523_shift_step

// File: rtl/serial_shifter.sv
// Bit-serial shifter: captures an operand and moves it one bit per clock until
// the requested amount has been applied, then pulses done_o for one cycle.
module serial_shifter
    import rv523_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   shamt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    shifter_state_e   state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    shift_op_e        op_q, op_d;
    logic [WIDTH-1:0] step_acc;
    logic             accept;

    // A start is only honoured from idle; elsewhere it is dropped.
    assign accept = (state_q == StIdle) && start_i;

    rv523_shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i (acc_q),
        .op_i  (op_q),
        .acc_o (step_acc)
    );

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: zero shift goes straight to done; last step (cnt==1) exits shift.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = (shamt_i == '0) ? StDone : StShift;
                end
            end
            StShift: begin
                if (cnt_q == SHW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath registers: accumulator, remaining count and latched operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            op_q  <= OpSll;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            op_q  <= op_d;
        end
    end

    // Datapath next-state: load on accepted start, one bit-step per shift cycle, else hold.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        op_d  = op_q;
        if (accept) begin
            acc_d = data_i;
            cnt_d = shamt_i;
            op_d  = shift_op_e'(op_i);
        end else if (state_q == StShift) begin
            acc_d = step_acc;
            cnt_d = cnt_q - SHW'(1);
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        busy_o = (state_q != StIdle);
        done_o = (state_q == StDone);
    end

    assign result_o = acc_q;

endmodule : serial_shifter

// File: tb/tb_serial_shifter.sv
// Directed self-checking bench for serial_shifter at WIDTH=32.
module tb_serial_shifter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SHW   = $clog2(WIDTH);

    logic             clk;
    logic             rst;
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] data_i;
    logic [SHW-1:0]   shamt_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;

    int checks = 0;
    int errors = 0;

    serial_shifter #(
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .op_i     (op_i),
        .data_i   (data_i),
        .shamt_i  (shamt_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one operation from idle; ends in the idle cycle after done_o.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] data,
                          input int shamt, input logic [31:0] exp_res);
        int n;
        int busy_n;
        start_i = 1'b1;
        op_i    = op;
        data_i  = data;
        shamt_i = SHW'(shamt);
        tick();
        start_i = 1'b0;
        data_i  = 32'h5555_AAAA;
        n       = 1;
        busy_n  = 0;
        while (!done_o && n < 100) begin
            if (busy_o) busy_n++;
            tick();
            n++;
        end
        if (busy_o) busy_n++;
        check_val({tag, " done_seen"}, {31'd0, done_o}, 32'd1);
        check_val({tag, " latency"}, n, shamt + 1);
        check_val({tag, " busy_cycles"}, busy_n, shamt + 1);
        check_val({tag, " result"}, result_o, exp_res);
        tick();
        check_val({tag, " done_one_cycle"}, {31'd0, done_o}, 32'd0);
        check_val({tag, " idle"}, {31'd0, busy_o}, 32'd0);
        check_val({tag, " held"}, result_o, exp_res);
    endtask

    initial begin
        int n;
        int seen_done;
        rst     = 1'b1;
        start_i = 1'b0;
        op_i    = 2'b00;
        data_i  = '0;
        shamt_i = '0;
        tick();
        tick();
        check_val("reset busy", {31'd0, busy_o}, 32'd0);
        check_val("reset done", {31'd0, done_o}, 32'd0);
        check_val("reset result", result_o, 32'h0);
        // Start held high during reset must be ignored.
        start_i = 1'b1;
        data_i  = 32'hFFFF_FFFF;
        shamt_i = 5'd3;
        tick();
        check_val("reset over start", {31'd0, busy_o}, 32'd0);
        start_i = 1'b0;
        rst     = 1'b0;
        tick();

        run_op("sll31", 2'b00, 32'h0000_0001, 31, 32'h8000_0000);
        run_op("sra4",  2'b10, 32'h8000_0000, 4,  32'hF800_0000);
        run_op("srl4",  2'b01, 32'h8000_0000, 4,  32'h0800_0000);
        run_op("rol1",  2'b11, 32'h8000_0001, 1,  32'h0000_0003);
        run_op("zero",  2'b01, 32'hDEAD_BEEF, 0,  32'hDEAD_BEEF);
        run_op("srapos", 2'b10, 32'h7000_0000, 8, 32'h0070_0000);
        run_op("rol4",  2'b11, 32'h1234_5678, 4,  32'h2345_6781);

        // Start during shift is ignored; the original operation completes intact.
        start_i = 1'b1;
        op_i    = 2'b00;
        data_i  = 32'h0000_0001;
        shamt_i = 5'd10;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        start_i = 1'b1;
        op_i    = 2'b11;
        data_i  = 32'hFFFF_0000;
        shamt_i = 5'd2;
        tick();
        start_i = 1'b0;
        n = 4;
        while (!done_o && n < 100) begin
            tick();
            n++;
        end
        check_val("ign latency", n, 11);
        check_val("ign result", result_o, 32'h0000_0400);
        // Start in the cycle right after done_o must be accepted.
        tick();
        run_op("back2back", 2'b01, 32'hF000_0000, 3, 32'h1E00_0000);

        // Reset in the middle of a shift aborts with no done pulse.
        start_i = 1'b1;
        op_i    = 2'b00;
        data_i  = 32'h0000_0001;
        shamt_i = 5'd10;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_val("pre-abort busy", {31'd0, busy_o}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("abort busy", {31'd0, busy_o}, 32'd0);
        check_val("abort result", result_o, 32'h0);
        seen_done = 0;
        for (int i = 0; i < 15; i++) begin
            if (done_o) seen_done++;
            tick();
        end
        check_val("abort no done", seen_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_shifter

// File: doc/serial_shifter.md
SERIAL_SHIFTER -- requirements
Module: serial_shifter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the clock port is clk and the reset port is rst.
REQ-002 Parameter: WIDTH, 32, data word width in bits; legal values are WIDTH >= 2.
REQ-003 Derived constant: SHW, $clog2(WIDTH), width of the shift-amount field; it SHALL NOT be overridable.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  synchronous reset, active high.
REQ-006 Port: start_i  input  1  request to begin an operation; sampled only in IDLE.
REQ-007 Port: op_i  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-008 Port: data_i  input  WIDTH  operand captured on an accepted start.
REQ-009 Port: shamt_i  input  SHW  shift amount captured on an accepted start.
REQ-010 Port: busy_o  output  1  high whenever the state is not IDLE.
REQ-011 Port: done_o  output  1  one-cycle completion pulse.
REQ-012 Port: result_o  output  WIDTH  accumulator contents; valid while done_o=1 and held until the next accepted start.

Function
REQ-013 The block SHALL shift the accumulator by exactly one bit position per clock, so that a shifter of any width costs one bit-step of logic.
REQ-014 The state machine SHALL have three states: IDLE, SHIFT and DONE.
REQ-015 In IDLE with start_i=1, the block SHALL load acc<=data_i, cnt<=shamt_i and op<=op_i, then go to DONE if shamt_i=0, otherwise to SHIFT.
REQ-016 In SHIFT, each cycle SHALL apply one bit-step and decrement cnt; when cnt=1 the next state SHALL be DONE.
REQ-017 Bit-steps: SLL={acc[W-2:0],0}; SRL={0,acc[W-1:1]}; SRA={acc[W-1],acc[W-1:1]}; ROL={acc[W-2:0],acc[W-1]}.
REQ-018 In DONE, done_o SHALL be 1 for exactly one cycle, after which the state SHALL return to IDLE unconditionally.
REQ-019 Latency: for a start sampled at edge k, done_o SHALL be high in the cycle following edge k+shamt; for shamt=0 that is the cycle immediately after the start edge.
REQ-020 start_i while in SHIFT or DONE SHALL be ignored, with no capture and no queueing.
REQ-021 Shift amounts >= WIDTH, possible only for non-power-of-two WIDTH, SHALL follow the serial semantics of REQ-016 and REQ-017: SLL/SRL give 0, SRA gives sign fill, ROL rotates modulo WIDTH.
REQ-022 result_o and op SHALL NOT change outside an accepted start or a SHIFT step.
REQ-023 busy_o and done_o SHALL be decoded from registered state only, with no combinational path from any input.

Reset
REQ-024 rst=1 at a clock edge SHALL force: state IDLE, acc 0, cnt 0, op SLL, busy_o 0, done_o 0, result_o 0.
REQ-025 Reset SHALL take priority over start_i and over any in-progress shift.
REQ-026 A reset during SHIFT or DONE SHALL abort the operation and SHALL NOT produce a done_o pulse.

Structure
REQ-027 The op encoding enum (SLL/SRL/SRA/ROL) and the state enum SHALL reside in the shared package rv523_pkg.
REQ-028 The single-bit step SHALL be a combinational sub-module, rv523_shift_step (inputs acc and op, output next acc), instantiated once and mapped onto the library gate cells.

Verification
REQ-029 WIDTH=32, SLL, data 0x00000001, shamt 31 -> busy_o for 32 cycles, done_o in cycle 32 after start, result_o 0x80000000.
REQ-030 SRA, data 0x80000000, shamt 4 -> result_o 0xF8000000; the same stimulus with SRL -> result_o 0x08000000.
REQ-031 ROL, data 0x80000001, shamt 1 -> result_o 0x00000003, with done_o in cycle 2.
REQ-032 shamt 0, data 0xDEADBEEF -> done_o in the cycle after start, result_o 0xDEADBEEF, SHIFT state never entered.
REQ-033 A second start_i pulse with new data during SHIFT -> ignored; the first result is unchanged, and a start in the cycle after done_o is accepted.
REQ-034 rst asserted mid-SHIFT (SLL 0x1, shamt 10, after 5 cycles) -> next cycle busy_o=0, result_o=0, and no done_o pulse occurs.
